// File: rtl/uart_axi_pkg.sv
// Shared types and constants for the UART AXI-Lite command arbiter.
// Holds the arbiter state encoding, default widths and the UART register map.
package uart_axi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 1024;

  localparam logic [31:0] UART_TX_ADDR     = 32'h0000_0004;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_0020;
  localparam logic [31:0] UART_RX_ADDR     = 32'h0000_0028;

  // Counter width for the WAIT timeout; keeps one bit when the timeout is disabled.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: one-hot grant to the first set request
// found when searching upward from ptr, wrapping at NUM_REQ.
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid
);

  int idx;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_axi_cmd_arbiter.sv
// Round-robin arbiter sharing the UART AXI-Lite command port between requesters:
// accept one command, issue one start pulse, wait for its done edge, respond once.
module uart_axi_cmd_arbiter
  import uart_axi_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      start_write,
  output logic                      start_read,
  output logic [ADDR_W-1:0]         write_address,
  output logic [ADDR_W-1:0]         read_address,
  output logic [DATA_W-1:0]         write_data,
  input  logic                      write_done,
  input  logic                      read_done,
  input  logic [DATA_W-1:0]         read_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_t         state_q, state_d;
  logic               armed_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wdone_q;
  logic               rdone_q;

  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic               accept;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               done_edge;
  logic               timeout_hit;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_grant (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // armed_q holds off acceptance until the first edge after reset release,
  // so req_ready stays low while rst_n is asserted even with requests pending.
  assign accept = (state_q == IDLE) && armed_q && grant_valid;

  always_comb begin
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx   = PTR_W'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the done line matching the command in flight counts, and only its rising edge.
  assign done_edge = we_q ? (write_done & ~wdone_q) : (read_done & ~rdone_q);

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    rsp_valid   = '0;
    start_write = 1'b0;
    start_read  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready = grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        start_write = we_q;
        start_read  = ~we_q;
        state_d     = WAIT;
      end
      WAIT: begin
        if (done_edge || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      wdone_q  <= 1'b0;
      rdone_q  <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      wdone_q <= write_done;
      rdone_q <= read_done;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= sel_idx;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_we ? sel_wdata : '0;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        WAIT: begin
          // A done edge in the timeout cycle still completes cleanly.
          if (done_edge) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : read_data;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          rr_ptr_q <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign write_address = addr_q;
  assign read_address  = addr_q;
  assign write_data    = wdata_q;
  assign rsp_err       = (state_q == RESP) && err_q;
  assign rsp_rdata     = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: doc/uart_axi_cmd_arbiter.md
# uart_axi_cmd_arbiter

Round-robin arbiter that shares the single AXI-Lite command port of the UART `top` between `NUM_REQ` requesters, such as a CPU-side bridge and a self-test sequencer. It accepts one command at a time and issues exactly one `start_write` or `start_read` pulse. It then waits for the matching `write_done`/`read_done` and returns a one-cycle response to the owning requester, with timeout protection. It sits directly in front of `top`, replacing direct drive of its command inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 1024: cycles allowed in WAIT before an error response; 0 disables the timeout.

- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  command pending, one bit per requester.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle response pulse.
- `rsp_err`  out  1  timeout flag; valid while `rsp_valid` is nonzero.
- `rsp_rdata`  out  DATA_W  read data; valid while `rsp_valid` is nonzero.
- `start_write`, `start_read`  out  1  one-cycle command pulses to `top`.
- `write_address`, `read_address`  out  ADDR_W  latched address, driven on both outputs.
- `write_data`  out  DATA_W  latched write data; 0 for reads.
- `write_done`, `read_done`  in  1  completion from `top`, pulse or level.
- `read_data`  in  DATA_W  read result from `top`.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. Reset enters IDLE.
- **IDLE**
  - Grant goes to the first requester with `req_valid` set, searching from round-robin pointer `rr_ptr`.
  - The arbiter pulses `req_ready[g]`, latches owner, we, addr and wdata, then goes to ISSUE.
  - With no valid requests it stays in IDLE.
- **ISSUE**
  - Pulses `start_write` if we=1, else `start_read`, for exactly one cycle.
  - Clears the WAIT counter and goes to WAIT.
- **WAIT**
  - Address and data outputs stay stable.
  - Completion is a rising edge of the expected done signal only (`write_done` for writes, `read_done` for reads), detected with registered `done_q`. The other done signal is ignored.
  - On a read edge, `read_data` is captured into `rsp_rdata`.
  - If the counter reaches `TIMEOUT` first: `rsp_err`=1, `rsp_rdata`=0.
  - Either outcome goes to RESP.
- **RESP**
  - Pulses `rsp_valid[owner]` for one cycle.
  - Sets `rr_ptr` = (owner+1) mod `NUM_REQ`, then returns to IDLE.
- Requester obligation: hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until `req_ready`. Fields are don't-care after accept.
- Downstream obligation: `top` deasserts its done signal before or on the next start, so a rising edge is guaranteed for each transaction.
- Reset values:
  - All outputs are 0.
  - `rr_ptr` = 0, `done_q` = 0.
  - Counter width is `$clog2(TIMEOUT+1)`.

## Timing
- Accept at cycle T; start pulse at T+1.
- Done edge sampled at cycle D (D ≥ T+2); `rsp_valid` at D+1.
- Next accept no earlier than D+2, giving 4 cycles minimum per transaction.
- Simultaneous requests: the requester nearest `rr_ptr` wins; the others wait with no lost requests.
- A new `req_valid` during WAIT or RESP is not accepted until IDLE.
- A done edge arriving in the same cycle as the timeout: the done edge wins and `rsp_err`=0.
- A done edge while not in WAIT is ignored, but `done_q` still tracks it.
- Reset mid-transaction:
  - The FSM returns to IDLE immediately.
  - No response is generated; the pending command is dropped.
  - `start_*` pulses stop immediately.

## Structure
- Package `uart_axi_pkg` holds:
  - the state enum `arb_state_t`;
  - default widths;
  - register map constants `UART_TX_ADDR`=0x04, `UART_STATUS_ADDR`=0x20 and `UART_RX_ADDR`=0x28.
- Sub-module `rr_grant`: combinational one-hot round-robin pick from `req_valid` and `rr_ptr`, parameterised by `NUM_REQ`. The top level owns the FSM, latches, counter and edge detection.

## Test plan
- **Single write:** req0 writes 0xA5 to 0x04; done after 5 cycles. Expect `req_ready[0]` at T, `start_write` at T+1, `write_address`=0x04, `write_data`=0xA5, `rsp_valid[0]` one cycle after the done edge, `rsp_err`=0.
- **Single read:** req1 reads 0x28; `top` returns 0x000000A5. Expect `start_read` only, `rsp_rdata`=0xA5, `rsp_valid[1]`.
- **Contention:** req0 and req1 valid from reset, each issuing 3 commands. Grants alternate 0,1,0,1,0,1; each requester gets exactly 3 responses.
- **Timeout:** `TIMEOUT`=16 and done is never asserted. Expect `rsp_err`=1 and `rsp_rdata`=0 exactly 16 cycles after WAIT entry, then the next request is served.
- **Level done:** `write_done` stays high until the next start. Expect one response per transaction and no spurious response.
- **Reset mid-WAIT:** `rst_n` low for 2 cycles during WAIT. All outputs 0, no `rsp_valid`; the next command completes normally with grant from requester 0.
